oup_ulpi_link_fsm: RTL
======================

// Module: oup_ulpi_link_fsm
// PURPOSE
//  ULPI link-side engine for the device controller, clocked by the PHY's 60 MHz ulpi_clk_i.
//  - Executes PHY register read/write instructions issued by the Wishbone register block.
//  - Captures RX CMD bytes the PHY sends when it owns the bus.
//  - Reports completion or abort back to the register block. CDC to the Wishbone domain is external.
// PARAMETERS
//  NXT_TIMEOUT  255  cycles to wait for ulpi_nxt_i while driving a byte; then abort (>=1)
//  EXT_ADDR_EN  1    1: extended register addressing allowed; 0: extended addresses abort
// PORTS
//  ulpi_clk_i          in   1  sole clock
//  rst_i               in   1  synchronous, active-high reset
//  ins_instruction_i   in   8  8'h01 REG_READ, 8'h02 REG_WRITE; all other codes illegal
//  ins_exec_i          in   1  1-cycle pulse: start instruction
//  ins_busy_o          out  1  request pending or FSM not in IDLE
//  ins_exec_done_o     out  1  1-cycle pulse: instruction finished (including aborts)
//  ins_exec_aborted_o  out  1  1-cycle pulse, coincident with done: instruction aborted
//  phyreg_addr_i       in   8  PHY register address; sampled at accept
//  phyreg_data_i       in   8  write data; sampled at accept
//  phyreg_data_o       out  8  read data; holds last successful read
//  phyreg_data_valid_o out  1  1-cycle pulse: phyreg_data_o updated
//  rx_cmd_byte_o       out  8  last RX CMD byte; holds value
//  rx_cmd_valid_o      out  1  1-cycle pulse: rx_cmd_byte_o updated
//  ulpi_data_i         in   8  ULPI data from the pad
//  ulpi_data_o         out  8  ULPI data to the pad
//  ulpi_data_oe_o      out  1  pad output enable; = drive_q & ~ulpi_dir_i (combinational)
//  ulpi_dir_i          in   1  PHY owns bus
//  ulpi_nxt_i          in   1  PHY throttle
//  ulpi_stp_o          out  1  link stop
// BEHAVIOUR
//  Reset
//  - All outputs 0; FSM in IDLE; pending cleared.
//  - Reset mid-operation: IDLE on the next edge, oe drops, no done pulse.
//  Accept
//  - ins_exec_i while idle and not pending: latch instruction, address and data; set pending.
//  - ins_exec_i while busy: ignored; produces no done.
//  - Illegal opcode: done+aborted 1 cycle after exec; no bus activity.
//  - Extended address: addr[7:6]!=0 or addr==8'h2F. With EXT_ADDR_EN=0 it aborts like an illegal opcode.
//  - Start: first IDLE cycle with ulpi_dir_i=0 and dir_q=0 (registered dir); pending clears.
//  States: IDLE, TXCMD, EXTADDR, WDATA, STP, RD_TURN, RD_DATA.
//  TXCMD
//  - Drive {2'b10 write | 2'b11 read, addr[5:0]}; field 6'h2F when the address is extended.
//  - Hold until ulpi_nxt_i=1, then go to EXTADDR (if extended), else WDATA (write) or RD_TURN (read).
//  EXTADDR: drive the full 8-bit address until nxt=1, then WDATA or RD_TURN.
//  WDATA: drive write data until nxt=1, then STP.
//  STP: one cycle, stp=1, data=8'h00, drive_q=0; pulse done; return to IDLE.
//  RD_TURN
//  - Turnaround cycle; link not driving.
//  - dir_i=1: go to RD_DATA; dir_i=0: abort.
//  RD_DATA
//  - dir_i=1, nxt_i=0: phyreg_data_o<=ulpi_data_i, valid+done pulse, IDLE.
//  - nxt_i=1 or dir_i=0: abort.
//  Aborts
//  - ulpi_dir_i=1 in TXCMD, EXTADDR or WDATA: oe drops in the same cycle; done+aborted pulse; IDLE.
//  - A nxt wait counter resets on each state entry. At NXT_TIMEOUT cycles without nxt: abort, drive_q=0, IDLE.
//  - Abort does not assert stp.
//  RX CMD
//  - Any cycle with dir_i=1, dir_q=1, nxt_i=0, outside RD_TURN and RD_DATA: rx_cmd_byte_o<=ulpi_data_i, valid pulse.
//  - The turnaround cycle (dir_i=1, dir_q=0) is never captured.
//  Latency: register write = accept + 1 start cycle + nxt waits + STP. Done pulses exactly once per accepted exec.
// TESTING
//  1. Write 0x0A<=0x55, nxt after 2 cycles. Required: data 0x8A until nxt, then 0x55; nxt; STP with data 0x00; done=1, aborted=0.
//  2. Read 0x16. Required: data 0xD6; nxt; dir=1 turn; PHY drives 0xA5. phyreg_data_o=0xA5, valid+done pulse, oe=0 from turn cycle.
//  3. Extended write 0x80<=0x3C. Required: 0xAF, then 0x80, then 0x3C, then STP; done. Repeat with EXT_ADDR_EN=0: done+aborted, bus idle.
//  4. dir=1 during TXCMD. Required: oe=0 same cycle; done+aborted. Next cycle dir=1, nxt=0, data 0x4C: rx_cmd_byte_o=0x4C, rx_cmd_valid_o pulse.
//  5. NXT_TIMEOUT=8, no nxt. Required: aborted 8 cycles after TXCMD entry; oe=0; IDLE.
//  6. rst_i in WDATA: next cycle oe=0, stp=0, no done. Exec while busy and opcode 0x7F: only 0x7F yields done+aborted.

Source files
------------

// File: rtl/oup_ulpi_link_fsm.sv
// ULPI link-side engine: runs PHY register read/write instructions over ULPI
// and captures RX CMD bytes while the PHY owns the bus.
//
// state     | meaning
// IDLE      | waiting for an accepted instruction and a free bus
// TXCMD     | driving the TX CMD byte, waiting for nxt
// EXTADDR   | driving the full extended register address, waiting for nxt
// WDATA     | driving write data, waiting for nxt
// STP       | one-cycle stop strobe closing a register write
// RD_TURN   | bus turnaround before read data; link released
// RD_DATA   | sampling read data from the PHY
module oup_ulpi_link_fsm #(
  parameter int NXT_TIMEOUT = 255,
  parameter bit EXT_ADDR_EN = 1'b1
) (
  input  logic       ulpi_clk_i,
  input  logic       rst_i,
  input  logic [7:0] ins_instruction_i,
  input  logic       ins_exec_i,
  output logic       ins_busy_o,
  output logic       ins_exec_done_o,
  output logic       ins_exec_aborted_o,
  input  logic [7:0] phyreg_addr_i,
  input  logic [7:0] phyreg_data_i,
  output logic [7:0] phyreg_data_o,
  output logic       phyreg_data_valid_o,
  output logic [7:0] rx_cmd_byte_o,
  output logic       rx_cmd_valid_o,
  input  logic [7:0] ulpi_data_i,
  output logic [7:0] ulpi_data_o,
  output logic       ulpi_data_oe_o,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o
);

  localparam int TW = (NXT_TIMEOUT > 1) ? $clog2(NXT_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(NXT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_TXCMD, S_EXTADDR, S_WDATA, S_STP, S_RD_TURN, S_RD_DATA
  } state_t;

  state_t        state_q, state_d;
  logic          pending_q, pending_d;
  logic          rd_q, rd_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q;
  logic          drive_q, drive_d;
  logic [7:0]    data_q, data_d;
  logic          stp_q, stp_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic [7:0]    phy_data_q, phy_data_d;
  logic          phy_valid_q, phy_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          abort, nxt_wait;
  logic          ins_legal, ins_ext, ext_q;

  assign ins_legal = (ins_instruction_i == 8'h01) || (ins_instruction_i == 8'h02);
  assign ins_ext   = (phyreg_addr_i[7:6] != 2'b00) || (phyreg_addr_i == 8'h2F);
  assign ext_q     = (addr_q[7:6] != 2'b00) || (addr_q == 8'h2F);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    timer_d     = timer_q;
    phy_data_d  = phy_data_q;
    rx_byte_d   = rx_byte_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    phy_valid_d = 1'b0;
    rx_valid_d  = 1'b0;
    abort       = 1'b0;
    nxt_wait    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ins_exec_i && !pending_q) begin
          if (!ins_legal || (ins_ext && !EXT_ADDR_EN)) begin
            done_d    = 1'b1;
            aborted_d = 1'b1;
          end else begin
            pending_d = 1'b1;
            rd_d      = (ins_instruction_i == 8'h01);
            addr_d    = phyreg_addr_i;
            wdata_d   = phyreg_data_i;
          end
        end else if (pending_q && !ulpi_dir_i && !dir_q) begin
          pending_d = 1'b0;
          state_d   = S_TXCMD;
          timer_d   = TLOAD;
        end
      end
      S_TXCMD: begin
        if (ulpi_dir_i) abort = 1'b1;
        else if (ulpi_nxt_i) begin
          state_d = ext_q ? S_EXTADDR : (rd_q ? S_RD_TURN : S_WDATA);
          timer_d = TLOAD;
        end else nxt_wait = 1'b1;
      end
      S_EXTADDR: begin
        if (ulpi_dir_i) abort = 1'b1;
        else if (ulpi_nxt_i) begin
          state_d = rd_q ? S_RD_TURN : S_WDATA;
          timer_d = TLOAD;
        end else nxt_wait = 1'b1;
      end
      S_WDATA: begin
        if (ulpi_dir_i) abort = 1'b1;
        else if (ulpi_nxt_i) begin
          state_d = S_STP;
          done_d  = 1'b1;
        end else nxt_wait = 1'b1;
      end
      S_STP: state_d = S_IDLE;
      S_RD_TURN: begin
        if (ulpi_dir_i) state_d = S_RD_DATA;
        else abort = 1'b1;
      end
      S_RD_DATA: begin
        if (ulpi_dir_i && !ulpi_nxt_i) begin
          phy_data_d  = ulpi_data_i;
          phy_valid_d = 1'b1;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else abort = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (nxt_wait) begin
      if (timer_q == '0) abort = 1'b1;
      else timer_d = timer_q - TW'(1);
    end

    if (abort) begin
      state_d   = S_IDLE;
      done_d    = 1'b1;
      aborted_d = 1'b1;
    end

    // The turnaround cycle (dir_q still low) is never an RX CMD.
    if (ulpi_dir_i && dir_q && !ulpi_nxt_i &&
        state_q != S_RD_TURN && state_q != S_RD_DATA) begin
      rx_byte_d  = ulpi_data_i;
      rx_valid_d = 1'b1;
    end

    drive_d = 1'b0;
    stp_d   = 1'b0;
    data_d  = 8'h00;
    case (state_d)
      S_TXCMD: begin
        drive_d = 1'b1;
        data_d  = {1'b1, rd_q, ext_q ? 6'h2F : addr_q[5:0]};
      end
      S_EXTADDR: begin
        drive_d = 1'b1;
        data_d  = addr_q;
      end
      S_WDATA: begin
        drive_d = 1'b1;
        data_d  = wdata_q;
      end
      S_STP:   stp_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ulpi_clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= 8'h00;
      wdata_q     <= 8'h00;
      timer_q     <= '0;
      dir_q       <= 1'b0;
      drive_q     <= 1'b0;
      data_q      <= 8'h00;
      stp_q       <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      phy_data_q  <= 8'h00;
      phy_valid_q <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      timer_q     <= timer_d;
      dir_q       <= ulpi_dir_i;
      drive_q     <= drive_d;
      data_q      <= data_d;
      stp_q       <= stp_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      phy_data_q  <= phy_data_d;
      phy_valid_q <= phy_valid_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign ins_busy_o          = pending_q | (state_q != S_IDLE);
  assign ins_exec_done_o     = done_q;
  assign ins_exec_aborted_o  = aborted_q;
  assign phyreg_data_o       = phy_data_q;
  assign phyreg_data_valid_o = phy_valid_q;
  assign rx_cmd_byte_o       = rx_byte_q;
  assign rx_cmd_valid_o      = rx_valid_q;
  assign ulpi_data_o         = data_q;
  assign ulpi_data_oe_o      = drive_q & ~ulpi_dir_i;
  assign ulpi_stp_o          = stp_q;

endmodule
